// File: rtl/z80_bus_master.sv
// Z80-style bus master: sequences IO write/read, interrupt acknowledge and RETI
// opcode fetches onto a peripheral bus, advancing one bus phase per enabled tick.
module z80_bus_master #(
   parameter int IO_WAIT = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clock_ena,
   input  logic       req,
   input  logic [1:0] cmd,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   input  logic       ack_en,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic [7:0] vector,
   output logic       vec_valid,
   output logic       ce_n,
   output logic [1:0] cs,
   output logic       m1_n,
   output logic       iorq_n,
   output logic       rd_n,
   output logic [7:0] dout,
   output logic [7:0] cpu_din,
   input  logic [7:0] din,
   input  logic       int_n
);

   typedef enum logic [3:0] {
      IDLE, IO_SETUP, IO_ACT, INTA_M1, INTA_ACT, RETI_F1, RETI_GAP, RETI_F2, FINISH
   } state_t;

   localparam logic [2:0] WAIT_LAST = 3'(IO_WAIT - 1);

   state_t     state;
   logic [2:0] cnt;
   logic       is_read;
   logic       is_inta;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         is_read   <= 1'b0;
         is_inta   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         vec_valid <= 1'b0;
         rdata     <= 8'h00;
         vector    <= 8'h00;
         ce_n      <= 1'b1;
         cs        <= 2'b00;
         m1_n      <= 1'b1;
         iorq_n    <= 1'b1;
         rd_n      <= 1'b1;
         dout      <= 8'h00;
         cpu_din   <= 8'hFF;
      end else begin
         // completion pulses last one clock even when ticks are sparse
         done      <= 1'b0;
         vec_valid <= 1'b0;
         if (clock_ena) begin
            cnt <= cnt + 3'd1;
            case (state)
               IDLE: begin
                  if (!int_n && ack_en) begin
                     state   <= INTA_M1;
                     cnt     <= 3'd0;
                     busy    <= 1'b1;
                     is_inta <= 1'b1;
                     m1_n    <= 1'b0;
                  end else if (req) begin
                     case (cmd)
                        2'b00, 2'b01: begin
                           state   <= IO_SETUP;
                           cnt     <= 3'd0;
                           busy    <= 1'b1;
                           is_inta <= 1'b0;
                           is_read <= cmd[0];
                           ce_n    <= 1'b0;
                           cs      <= addr;
                           rd_n    <= !cmd[0];
                           dout    <= cmd[0] ? 8'h00 : wdata;
                        end
                        2'b10: begin
                           state   <= RETI_F1;
                           cnt     <= 3'd0;
                           busy    <= 1'b1;
                           is_inta <= 1'b0;
                           m1_n    <= 1'b0;
                           rd_n    <= 1'b0;
                           cpu_din <= 8'hED;
                        end
                        default: done <= 1'b1;
                     endcase
                  end
               end
               IO_SETUP: begin
                  state  <= IO_ACT;
                  cnt    <= 3'd0;
                  iorq_n <= 1'b0;
               end
               IO_ACT: begin
                  if (cnt == WAIT_LAST) begin
                     state  <= FINISH;
                     cnt    <= 3'd0;
                     iorq_n <= 1'b1;
                     rd_n   <= 1'b1;
                     if (is_read) rdata <= din;
                  end
               end
               INTA_M1: begin
                  state  <= INTA_ACT;
                  cnt    <= 3'd0;
                  iorq_n <= 1'b0;
               end
               INTA_ACT: begin
                  if (cnt == WAIT_LAST) begin
                     state     <= FINISH;
                     cnt       <= 3'd0;
                     m1_n      <= 1'b1;
                     iorq_n    <= 1'b1;
                     vector    <= din;
                     vec_valid <= 1'b1;
                  end
               end
               RETI_F1: begin
                  if (cnt == 3'd1) begin
                     state   <= RETI_GAP;
                     cnt     <= 3'd0;
                     m1_n    <= 1'b1;
                     rd_n    <= 1'b1;
                     cpu_din <= 8'hFF;
                  end
               end
               RETI_GAP: begin
                  state   <= RETI_F2;
                  cnt     <= 3'd0;
                  m1_n    <= 1'b0;
                  rd_n    <= 1'b0;
                  cpu_din <= 8'h4D;
               end
               RETI_F2: begin
                  if (cnt == 3'd1) begin
                     state   <= FINISH;
                     cnt     <= 3'd0;
                     m1_n    <= 1'b1;
                     rd_n    <= 1'b1;
                     cpu_din <= 8'hFF;
                  end
               end
               FINISH: begin
                  // chip select and write data stay put through FINISH, dropped here
                  state <= IDLE;
                  cnt   <= 3'd0;
                  ce_n  <= 1'b1;
                  cs    <= 2'b00;
                  dout  <= 8'h00;
                  busy  <= 1'b0;
                  done  <= !is_inta;
               end
               default: begin
                  state <= IDLE;
                  cnt   <= 3'd0;
               end
            endcase
         end
      end
   end

endmodule
